// File: rtl/bb_prng_host.sv
// Host-side sequencer for the BB_SYSTEM PRNG: nibble-wise seed loads, sample fetches into a FWFT FIFO.
// Optional feature macro: BB_PRNG_HOST_AUTORAND_EN (seed load chains straight into a sample fetch).
module bb_prng_host #(
  parameter int SEED_NIBBLES = 4,
  parameter int RAND_LATENCY = 1,
  parameter int GAP_CYCLES   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      BB_SYSTEM_CLOCK_50,
  input  logic                      BB_SYSTEM_RESET_InHigh,
  input  logic [4*SEED_NIBBLES-1:0] host_seed_InBUS,
  input  logic                      host_seedstart_In,
  input  logic [7:0]                host_randcount_InBUS,
  input  logic                      host_randstart_In,
  output logic                      host_busy_Out,
  output logic                      prng_loadseed_OutLow,
  output logic                      prng_loadrand_OutLow,
  output logic [3:0]                prng_data_OutBUS,
  input  logic [7:0]                prng_data_InBUS,
  output logic [7:0]                fifo_data_OutBUS,
  output logic                      fifo_valid_Out,
  input  logic                      fifo_ready_In
);

  localparam int SW = 4 * SEED_NIBBLES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0]    LAT_LAST  = 8'(RAND_LATENCY - 1);
  localparam logic [7:0]    NIB_TOTAL = 8'(SEED_NIBBLES);
  localparam logic [PW-1:0] FULL_CNT  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] ZERO_CNT  = {PW{1'b0}};

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEED_STROBE = 3'd1,
    SEED_GAP    = 3'd2,
    RAND_REQ    = 3'd3,
    RAND_WAIT   = 3'd4,
    RAND_GAP    = 3'd5
  } stateT;

  stateT         stateR, stateNextS;
  logic [7:0]    cntR;
  logic [SW-1:0] seedR, seedNextS;
  logic [7:0]    nibLeftR, nibLeftNextS;
  logic [7:0]    randLeftR, randLeftNextS;
  logic          pushS, popS;
  logic          loadseedR, loadrandR, busyR;
  logic [3:0]    seedDataR;

  logic [7:0]    memR [FIFO_DEPTH];
  logic [PW-1:0] wrPtrR, rdPtrR;
  logic [PW-1:0] countS, afterPopS, countNextS;
  logic [AW-1:0] rdIdxNextS;
  logic          fifoFullNextS;
  logic          fifoValidR;
  logic [7:0]    fifoDataR, headNextS;

  // Next-state and per-phase bookkeeping for the seed/sample sequencer
  always_comb begin
    stateNextS    = stateR;
    seedNextS     = seedR;
    nibLeftNextS  = nibLeftR;
    randLeftNextS = randLeftR;
    pushS         = 1'b0;
    case (stateR)
      IDLE: begin
        if (host_seedstart_In) begin
          stateNextS   = SEED_STROBE;
          seedNextS    = host_seed_InBUS;
          nibLeftNextS = NIB_TOTAL;
`ifdef BB_PRNG_HOST_AUTORAND_EN
          randLeftNextS = host_randcount_InBUS;
`else
          randLeftNextS = randLeftR;
`endif
        end else if (host_randstart_In) begin
          randLeftNextS = host_randcount_InBUS;
          // A zero count never leaves IDLE, so no strobe and no busy cycle
          if (host_randcount_InBUS != 8'd0) begin
            stateNextS = RAND_REQ;
          end else begin
            stateNextS = IDLE;
          end
        end else begin
          stateNextS = IDLE;
        end
      end
      SEED_STROBE: stateNextS = SEED_GAP;
      SEED_GAP: begin
        if (cntR == GAP_LAST) begin
          if (nibLeftR == 8'd1) begin
            nibLeftNextS = 8'd0;
`ifdef BB_PRNG_HOST_AUTORAND_EN
            if (randLeftR != 8'd0) begin
              stateNextS = RAND_REQ;
            end else begin
              stateNextS = IDLE;
            end
`else
            stateNextS = IDLE;
`endif
          end else begin
            stateNextS   = SEED_STROBE;
            seedNextS    = seedR >> 3'd4;
            nibLeftNextS = nibLeftR - 8'd1;
          end
        end else begin
          stateNextS = SEED_GAP;
        end
      end
      RAND_REQ: begin
        // The registered strobe is only driven low when the FIFO has room
        if (!loadrandR) begin
          stateNextS = RAND_WAIT;
        end else begin
          stateNextS = RAND_REQ;
        end
      end
      RAND_WAIT: begin
        if (cntR == LAT_LAST) begin
          pushS      = 1'b1;
          stateNextS = RAND_GAP;
        end else begin
          stateNextS = RAND_WAIT;
        end
      end
      RAND_GAP: begin
        if (cntR == GAP_LAST) begin
          randLeftNextS = randLeftR - 8'd1;
          if (randLeftR != 8'd1) begin
            stateNextS = RAND_REQ;
          end else begin
            stateNextS = IDLE;
          end
        end else begin
          stateNextS = RAND_GAP;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // FIFO occupancy and next head word after this cycle's push/pop
  always_comb begin
    countS        = wrPtrR - rdPtrR;
    popS          = (countS != ZERO_CNT) && fifo_ready_In;
    afterPopS     = countS - PW'(popS);
    countNextS    = afterPopS + PW'(pushS);
    fifoFullNextS = (countNextS == FULL_CNT);
    rdIdxNextS    = rdPtrR[AW-1:0] + AW'(popS);
    if (countNextS == ZERO_CNT) begin
      headNextS = fifoDataR;
    end else if (afterPopS == ZERO_CNT) begin
      headNextS = prng_data_InBUS;
    end else begin
      headNextS = memR[rdIdxNextS];
    end
  end

  // Sequencer state, counters and registered generator-side outputs
  always_ff @(posedge BB_SYSTEM_CLOCK_50) begin
    if (BB_SYSTEM_RESET_InHigh) begin
      stateR    <= IDLE;
      cntR      <= 8'd0;
      seedR     <= {SW{1'b0}};
      nibLeftR  <= 8'd0;
      randLeftR <= 8'd0;
      loadseedR <= 1'b1;
      loadrandR <= 1'b1;
      busyR     <= 1'b0;
      seedDataR <= 4'd0;
    end else begin
      stateR    <= stateNextS;
      cntR      <= (stateNextS != stateR) ? 8'd0 : cntR + 8'd1;
      seedR     <= seedNextS;
      nibLeftR  <= nibLeftNextS;
      randLeftR <= randLeftNextS;
      loadseedR <= (stateNextS != SEED_STROBE);
      loadrandR <= !((stateNextS == RAND_REQ) && !fifoFullNextS);
      busyR     <= (stateNextS != IDLE);
      if (stateNextS == SEED_STROBE) begin
        seedDataR <= seedNextS[3:0];
      end
    end
  end

  // FIFO pointers and registered head/valid
  always_ff @(posedge BB_SYSTEM_CLOCK_50) begin
    if (BB_SYSTEM_RESET_InHigh) begin
      wrPtrR     <= ZERO_CNT;
      rdPtrR     <= ZERO_CNT;
      fifoValidR <= 1'b0;
      fifoDataR  <= 8'd0;
    end else begin
      wrPtrR     <= wrPtrR + PW'(pushS);
      rdPtrR     <= rdPtrR + PW'(popS);
      fifoValidR <= (countNextS != ZERO_CNT);
      fifoDataR  <= headNextS;
    end
  end

  // FIFO storage
  always_ff @(posedge BB_SYSTEM_CLOCK_50) begin
    if (pushS && !BB_SYSTEM_RESET_InHigh) begin
      memR[wrPtrR[AW-1:0]] <= prng_data_InBUS;
    end
  end

  assign host_busy_Out        = busyR;
  assign prng_loadseed_OutLow = loadseedR;
  assign prng_loadrand_OutLow = loadrandR;
  assign prng_data_OutBUS     = seedDataR;
  assign fifo_data_OutBUS     = fifoDataR;
  assign fifo_valid_Out       = fifoValidR;

endmodule

// File: tb/tb_bb_prng_host.sv
// Scoreboard bench for bb_prng_host: expected strobes/samples are queued at stimulus time,
// monitors compare them as the DUT presents them. Honours BB_PRNG_HOST_AUTORAND_EN.
module tb_bb_prng_host;
  localparam int SN = 4;
  localparam int LAT = 1;
  localparam int GAP = 1;
  localparam int DEPTH = 4;
  localparam int SP = 1 + GAP;
  localparam int RP = 1 + LAT + GAP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*SN-1:0] seedIn = '0;
  logic          seedStartIn = 1'b0;
  logic [7:0]    countIn = 8'd0;
  logic          randStartIn = 1'b0;
  logic          busy, loadseedN, loadrandN, validOut;
  logic [3:0]    nibOut;
  logic [7:0]    genData = 8'd0;
  logic [7:0]    fifoData;
  logic          ready = 1'b1;

  bb_prng_host #(.SEED_NIBBLES(SN), .RAND_LATENCY(LAT), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .BB_SYSTEM_CLOCK_50(clk), .BB_SYSTEM_RESET_InHigh(rst),
    .host_seed_InBUS(seedIn), .host_seedstart_In(seedStartIn),
    .host_randcount_InBUS(countIn), .host_randstart_In(randStartIn),
    .host_busy_Out(busy), .prng_loadseed_OutLow(loadseedN), .prng_loadrand_OutLow(loadrandN),
    .prng_data_OutBUS(nibOut), .prng_data_InBUS(genData),
    .fifo_data_OutBUS(fifoData), .fifo_valid_Out(validOut), .fifo_ready_In(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } expT;
  expT        expSeedQ[$];
  int         expRandQ[$];
  logic [7:0] expFifoQ[$];
  logic [7:0] forcedQ[$];
  int  checks = 0, errors = 0, randStrobes = 0, pops = 0;
  bit  randTiming = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: strobes and FIFO pops against the scoreboard queues
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (loadseedN === 1'b0) begin
        if (expSeedQ.size() == 0) failNow("seed_strobe_unexpected");
        else begin
          e = expSeedQ.pop_front();
          chk("seed_strobe_cycle", cyc, e.cyc);
          chk("seed_nibble", nibOut, e.val);
        end
      end
      if (loadrandN === 1'b0) begin
        randStrobes++;
        if (randTiming) begin
          if (expRandQ.size() == 0) failNow("rand_strobe_unexpected");
          else chk("rand_strobe_cycle", cyc, expRandQ.pop_front());
        end
      end
      if (validOut === 1'b1 && ready === 1'b1) begin
        pops++;
        if (expFifoQ.size() == 0) failNow("fifo_pop_unexpected");
        else chk("fifo_data", fifoData, expFifoQ.pop_front());
      end
    end
  end

  // Generator model: answers each loadrand strobe after LAT cycles, garbage otherwise
  initial begin
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (loadrandN === 1'b0) begin
        v = (forcedQ.size() > 0) ? forcedQ.pop_front() : 8'($urandom);
        tick();
        for (int i = 1; i < LAT; i++) begin
          genData = 8'($urandom);
          tick();
        end
        genData = v;
        expFifoQ.push_back(v);
        tick();
        genData = 8'($urandom);
        @(negedge clk);
        chk("capture_visible", validOut, 1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  task automatic seedStart(input logic [4*SN-1:0] seed, input logic [7:0] count, input int nExp,
                           output int t, output int expFall);
    logic [4*SN-1:0] sh;
    seedIn = seed;
    countIn = count;
    seedStartIn = 1'b1;
    t = cyc;
    for (int i = 0; i < nExp; i++) begin
      sh = seed >> (4 * i);
      expSeedQ.push_back('{t + 1 + i * SP, int'(sh[3:0])});
    end
    expFall = t + 1 + SN * SP;
`ifdef BB_PRNG_HOST_AUTORAND_EN
    for (int k = 0; k < int'(count); k++) expRandQ.push_back(t + 1 + SN * SP + k * RP);
    expFall = expFall + int'(count) * RP;
`endif
    tick();
    seedStartIn = 1'b0;
    seedIn = 16'($urandom);
    countIn = 8'($urandom);
  endtask

  task automatic randStart(input logic [7:0] count, input bit timing, output int t, output int expFall);
    countIn = count;
    randStartIn = 1'b1;
    randTiming = timing;
    t = cyc;
    if (timing) for (int k = 0; k < int'(count); k++) expRandQ.push_back(t + 1 + k * RP);
    expFall = (count == 8'd0) ? t + 1 : t + 1 + int'(count) * RP;
    tick();
    randStartIn = 1'b0;
    countIn = 8'($urandom);
  endtask

  task automatic waitIdle(input int budget, input bit randReady, output int fall);
    int n = 0;
    fall = -1;
    while (n < budget) begin
      @(negedge clk);
      if (!busy) begin
        fall = cyc;
        break;
      end
      tick();
      if (randReady) ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (fall < 0) failNow("busy_timeout");
    tick();
  endtask

  task automatic drain();
    int n = 0;
    ready = 1'b1;
    while (expFifoQ.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("fifo_drained", expFifoQ.size(), 0);
    chk("fifo_empty_valid", validOut, 0);
  endtask

  initial begin
    int t, ef, fall, s0, p0, cnt;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_loadseed", loadseedN, 1);
    chk("rst_loadrand", loadrandN, 1);
    chk("rst_nibble", nibOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", validOut, 0);
    chk("rst_fifo_data", fifoData, 0);
    tick();
    rst = 1'b0;
    tick();

    // Seed loads: directed then random
    seedStart(16'hA53C, 8'd0, SN, t, ef);
    waitIdle(100, 1'b0, fall);
    chk("seed_busy_fall", fall, t + 9);
    for (int i = 0; i < 3; i++) begin
      seedStart(16'($urandom), 8'd0, SN, t, ef);
      waitIdle(100, 1'b0, fall);
      chk("seed_busy_fall_rnd", fall, ef);
    end

    // Directed fetch of three known samples
    forcedQ = '{8'h11, 8'h22, 8'h33};
    s0 = randStrobes;
    randStart(8'd3, 1'b1, t, ef);
    waitIdle(100, 1'b0, fall);
    chk("rand_busy_fall", fall, t + 10);
    chk("rand_strobe_count", randStrobes - s0, 3);
    drain();

    // Random fetches, consumer always ready
    for (int i = 0; i < 4; i++) begin
      randStart(8'($urandom_range(1, 6)), 1'b1, t, ef);
      waitIdle(200, 1'b0, fall);
      chk("rand_busy_fall_rnd", fall, ef);
      drain();
    end

    // Random fetches with a randomly stalling consumer
    for (int i = 0; i < 2; i++) begin
      cnt = $urandom_range(3, 8);
      s0 = randStrobes;
      p0 = pops;
      randStart(8'(cnt), 1'b0, t, ef);
      waitIdle(400, 1'b1, fall);
      drain();
      chk("rndready_strobes", randStrobes - s0, cnt);
      chk("rndready_pops", pops - p0, cnt);
    end

    // Full FIFO stalls the fetch; no sample lost once drained
    ready = 1'b0;
    s0 = randStrobes;
    p0 = pops;
    randStart(8'd6, 1'b0, t, ef);
    repeat (25) tick();
    chk("stall_strobes", randStrobes - s0, 4);
    chk("stall_busy", busy, 1);
    chk("stall_strobe_high", loadrandN, 1);
    chk("stall_valid", validOut, 1);
    ready = 1'b1;
    waitIdle(100, 1'b0, fall);
    chk("stall_total_strobes", randStrobes - s0, 6);
    drain();
    chk("stall_total_pops", pops - p0, 6);

    // Simultaneous starts: seed wins; randstart while busy ignored
    randTiming = 1'b1;
    s0 = randStrobes;
    randStartIn = 1'b1;
    seedStart(16'h1234, 8'd5, SN, t, ef);
    randStartIn = 1'b0;
    tick();
    tick();
    randStartIn = 1'b1;
    tick();
    randStartIn = 1'b0;
    waitIdle(200, 1'b0, fall);
    chk("both_busy_fall", fall, ef);
`ifdef BB_PRNG_HOST_AUTORAND_EN
    chk("both_rand_strobes", randStrobes - s0, 5);
`else
    chk("both_rand_strobes", randStrobes - s0, 0);
`endif
    drain();

    // Zero count: no strobe, never busy
    s0 = randStrobes;
    randStart(8'd0, 1'b1, t, ef);
    waitIdle(20, 1'b0, fall);
    chk("zero_busy_fall", fall, t + 1);
    repeat (5) tick();
    chk("zero_strobes", randStrobes - s0, 0);

    // Reset during the second nibble's gap, with one sample held in the FIFO
    ready = 1'b0;
    randStart(8'd1, 1'b1, t, ef);
    waitIdle(20, 1'b0, fall);
    seedStart(16'hBEEF, 8'd0, 2, t, ef);
    tick();
    tick();
    tick();
    rst = 1'b1;
    expFifoQ.delete();
    tick();
    @(negedge clk);
    chk("midrst_loadseed", loadseedN, 1);
    chk("midrst_loadrand", loadrandN, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", validOut, 0);
    tick();
    rst = 1'b0;
    ready = 1'b1;
    repeat (15) tick();
    chk("midrst_seed_queue", expSeedQ.size(), 0);

    // Seed load with a latched count (chains into a fetch only when autorand is built in)
    seedStart(16'h0F5A, 8'd2, SN, t, ef);
    waitIdle(200, 1'b0, fall);
    chk("auto_busy_fall", fall, ef);
    drain();

    repeat (5) tick();
    chk("end_seed_queue", expSeedQ.size(), 0);
    chk("end_rand_queue", expRandQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
